// File: rtl/vec_mag_pkg.sv
// Shared definitions for the vector-magnitude unit: FSM states and width helpers.
package vec_mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // x^2 + y^2 needs one bit beyond 2W
  function automatic int sum_w(input int w);
    return 2 * w + 1;
  endfunction

  // ceil(sqrt(2) * (2^W - 1)) always fits in W+1 bits
  function automatic int out_w(input int w);
    return w + 1;
  endfunction

  // Root bit index runs W..0
  function automatic int idx_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/vec_mag_isqrt.sv
// Iterative digit-by-digit square-root core, one result bit per step.
// With VEC_MAG_ROUND_EN defined, res is round-to-nearest instead of floor.
import vec_mag_pkg::*;

module vec_mag_isqrt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic         step,
  input  logic [2*W:0] sum_in,
  output logic         last,
  output logic [W:0]   res
);

  localparam int SUM_W = sum_w(W);
  localparam int OUT_W = out_w(W);
  localparam int SQ_W  = 2 * OUT_W;
  localparam int IW    = idx_w(W);

  logic [SUM_W-1:0] sum;
  logic [OUT_W-1:0] root;
  logic [SQ_W-1:0]  sq;
  logic [IW-1:0]    idx;

  logic [OUT_W-1:0] bit_v, trial, root_nx;
  logic [SQ_W-1:0]  sum_x, trial_sq, sq_nx;
  logic [IW:0]      sh_cross, sh_sq;
  logic             fit;

  // sq tracks root^2, so trial^2 = sq + 2*root*2^idx + 4^idx; root's set bits
  // are all above idx, which keeps this a pure shift/add update.
  always_comb begin
    bit_v    = OUT_W'(1) << idx;
    trial    = root | bit_v;
    sh_cross = {1'b0, idx} + (IW+1)'(1);
    sh_sq    = {idx, 1'b0};
    sum_x    = SQ_W'(sum);
    trial_sq = sq + (SQ_W'(root) << sh_cross) + (SQ_W'(1) << sh_sq);
    fit      = (trial_sq <= sum_x);
    root_nx  = fit ? trial : root;
    sq_nx    = fit ? trial_sq : sq;
  end

  assign last = (idx == '0);

`ifdef VEC_MAG_ROUND_EN
  logic [SQ_W-1:0] rem;
  logic            round_up;
  always_comb begin
    rem      = sum_x - sq_nx;
    round_up = (rem > SQ_W'(root_nx));
    res      = root_nx + OUT_W'(round_up);
  end
`else
  assign res = root_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      root <= '0;
      sq   <= '0;
      idx  <= '0;
    end else if (ena) begin
      if (start) begin
        sum  <= sum_in;
        root <= '0;
        sq   <= '0;
        idx  <= IW'(W);
      end else if (step) begin
        root <= root_nx;
        sq   <= sq_nx;
        if (idx != '0) idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: rtl/vec_mag_sqrt.sv
// Streaming floor(sqrt(x^2 + y^2)) with valid/ready on both sides.
// Define VEC_MAG_ROUND_EN for a round-to-nearest result.
import vec_mag_pkg::*;

module vec_mag_sqrt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   mag
);

  localparam int SUM_W = sum_w(W);
  localparam int OUT_W = out_w(W);

  state_t           state, state_nxt;
  logic [W-1:0]     xr, yr;
  logic [SUM_W-1:0] sq_sum;
  logic             start, step, last;
  logic [OUT_W-1:0] res;

  assign sq_sum   = SUM_W'(xr) * SUM_W'(xr) + SUM_W'(yr) * SUM_W'(yr);
  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nxt = SQ;
      SQ: begin
        start     = 1'b1;
        state_nxt = ITER;
      end
      ITER: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  // Operands are captured only on the input handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr <= '0;
      yr <= '0;
    end else if (ena && state == IDLE && in_valid) begin
      xr <= x;
      yr <= y;
    end
  end

  // Result lands on the same edge as the final root bit, so DONE shows it at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mag       <= '0;
    end else if (ena) begin
      if (state == ITER && last) begin
        out_valid <= 1'b1;
        mag       <= res;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  vec_mag_isqrt #(.W(W)) u_isqrt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (start),
    .step   (step),
    .sum_in (sq_sum),
    .last   (last),
    .res    (res)
  );

endmodule

// File: tb/tb_vec_mag_sqrt.sv
// Self-checking bench: W=8 directed table and corner sequences, W=16 random sweep.
module tb_vec_mag_sqrt;

  logic clk, rst_n;
  int   cyc;
  int   errors, checks;

  logic       ena8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] x8, y8;
  logic [8:0] mag8;

  logic        ena16, in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] x16, y16;
  logic [16:0] mag16;

  vec_mag_sqrt #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8), .mag(mag8)
  );

  vec_mag_sqrt #(.W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .ena(ena16), .in_valid(in_valid16), .in_ready(in_ready16),
    .x(x16), .y(y16), .out_valid(out_valid16), .out_ready(out_ready16), .mag(mag16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sqrt by bisection on plain arithmetic
  function automatic longint ref_mag(input longint a, input longint b);
    longint s, lo, hi, mid;
    s  = a * a + b * b;
    lo = 0;
    hi = 64'd1 << 18;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid;
    end
`ifdef VEC_MAG_ROUND_EN
    if (s - lo * lo > lo) lo = lo + 1;
`endif
    return lo;
  endfunction

  // Called at posedge+#1. Keeps in_valid high with junk operands while busy
  // (must be ignored); optional ena gap of ena_gap cycles starting mid-ITER.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int ena_gap,
                      output int lat, output int acc, output int m);
    chk("in_ready8_before_accept", in_ready8, 1);
    x8 = a; y8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    x8 = 8'($urandom); y8 = 8'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 60) begin
      if (ena_gap > 0 && lat == 4) begin
        ena8 = 1'b0;
        repeat (ena_gap) begin
          @(posedge clk); #1; lat++;
        end
        ena8 = 1'b1;
      end else begin
        @(posedge clk); #1; lat++;
      end
    end
    in_valid8 = 1'b0;
    m = mag8;
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         exp_mag;
  } vec_t;

  vec_t tbl[7];
  int   lat, acc, acc0, m;

  initial begin
    errors = 0; checks = 0; cyc = 0;
    tbl[0] = '{8'd3,   8'd4,   5};
`ifdef VEC_MAG_ROUND_EN
    tbl[1] = '{8'd255, 8'd255, 361};
`else
    tbl[1] = '{8'd255, 8'd255, 360};
`endif
    tbl[2] = '{8'd1,   8'd1,   1};
    tbl[3] = '{8'd0,   8'd0,   0};
    tbl[4] = '{8'd6,   8'd8,   10};
    tbl[5] = '{8'd5,   8'd12,  13};
    tbl[6] = '{8'd20,  8'd21,  29};

    rst_n = 1'b0;
    ena8 = 1'b1; in_valid8 = 1'b0; x8 = '0; y8 = '0; out_ready8 = 1'b1;
    ena16 = 1'b1; in_valid16 = 1'b0; x16 = '0; y16 = '0; out_ready16 = 1'b1;
    #12;
    chk("reset_out_valid", out_valid8, 0);
    chk("reset_mag", mag8, 0);
    chk("reset_in_ready", in_ready8, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) begin
      run8(tbl[i].x, tbl[i].y, 0, lat, acc, m);
      chk($sformatf("tbl%0d_mag", i), m, tbl[i].exp_mag);
      chk($sformatf("tbl%0d_latency", i), lat, 10);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid_cleared", i), out_valid8, 0);
      chk($sformatf("tbl%0d_in_ready_after", i), in_ready8, 1);
    end

    // Back-to-back throughput
    run8(8'd3, 8'd4, 0, lat, acc0, m);
    @(posedge clk); #1;
    run8(8'd7, 8'd24, 0, lat, acc, m);
    chk("throughput_period", acc - acc0, 12);
    chk("throughput_mag", m, 25);
    @(posedge clk); #1;

    // Back-pressure
    out_ready8 = 1'b0;
    run8(8'd6, 8'd8, 0, lat, acc, m);
    chk("bp_mag", m, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", i), out_valid8, 1);
      chk($sformatf("bp%0d_mag", i), mag8, 10);
      chk($sformatf("bp%0d_in_ready", i), in_ready8, 0);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid8, 0);
    chk("bp_release_in_ready", in_ready8, 1);

    // Asynchronous reset mid-ITER
    x8 = 8'd200; y8 = 8'd100; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid8, 0);
    chk("rst_mid_mag", mag8, 0);
    chk("rst_mid_in_ready", in_ready8, 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_out_valid", out_valid8, 0);
    run8(8'd5, 8'd12, 0, lat, acc, m);
    chk("rst_after_mag", m, 13);
    chk("rst_after_latency", lat, 10);
    @(posedge clk); #1;

    // ena low for 3 cycles mid-ITER
    run8(8'd9, 8'd40, 3, lat, acc, m);
    chk("ena_gap_mag", m, 41);
    chk("ena_gap_latency", lat, 13);
    @(posedge clk); #1;

    // W=16 random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      int l16;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0) begin a = 16'd0; b = 16'd0; end
      if (i == 1) begin a = 16'hffff; b = 16'hffff; end
      if (i == 2) begin a = 16'd1; b = 16'd1; end
      if (i == 3) begin a = 16'hffff; b = 16'd0; end
      if (!in_ready16) chk("w16_in_ready", in_ready16, 1);
      x16 = a; y16 = b; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      x16 = 16'($urandom); y16 = 16'($urandom);
      l16 = 0;
      while (!out_valid16 && l16 < 60) begin
        @(posedge clk); #1; l16++;
      end
      chk($sformatf("w16_mag x=%0d y=%0d", a, b), mag16, ref_mag(a, b));
      chk($sformatf("w16_latency x=%0d y=%0d", a, b), l16, 18);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_mag_sqrt.md
# vec_mag_sqrt

Parametrised streaming vector-magnitude unit: computes floor(sqrt(x² + y²)) for unsigned W-bit operands, or the rounded value when configured. It uses an iterative digit-by-digit square root that resolves one result bit per cycle. It is the next-generation magnitude block for the tile datapath, adding operand width scaling, valid/ready handshakes on both sides and back-pressure. The block sits between the operand capture logic and the tile output register stage.

## Interface
- W, default 8: operand width, legal range 2..16. Derived widths: SUM_W = 2W+1, OUT_W = W+1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  global enable; when low, all state and outputs hold.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- x  input  W  operand x, unsigned.
- y  input  W  operand y, unsigned.
- out_valid  output  1  mag is valid; held until the output handshake completes.
- out_ready  input  1  downstream accepts the result.
- mag  output  OUT_W  magnitude result, unsigned.

## Operation
- FSM states and transitions:
  - IDLE: on in_valid && in_ready && ena, register x and y, then go to SQ.
  - SQ: sum <= x² + y², computed at SUM_W bits with no overflow. Clear root. Set bit index to W. Go to ITER.
  - ITER: trial = root | (1 << idx). If trial² ≤ sum, root <= trial. When idx = 0, go to DONE; otherwise decrement idx. This takes W+1 cycles in total.
  - DONE: mag <= final root, with rounding applied if configured, and out_valid = 1. On out_valid && out_ready && ena, go to IDLE.
- The implementation may use a remainder/partial-product form instead of the trial² compare. The result must be bit-identical.
- All arithmetic is unsigned. The maximum result is ceil(sqrt(2)·(2^W−1)), which always fits in OUT_W bits.
- in_ready = (state == IDLE) && !reset. There is no combinational path from out_ready to in_ready.
- mag and out_valid are registered, and mag is stable for as long as out_valid is high.
- Operand inputs are sampled only at the input handshake. Changes to x or y after that edge have no effect.
- ena low in any state freezes the FSM, idx, root and sum. Handshakes are not recognised while ena is low.
- in_valid in non-IDLE states is ignored, and nothing is queued.
- Reset mid-operation (any state) aborts the computation. No partial result is ever presented.

## Timing
- Reset values:
  - out_valid = 0, mag = 0, in_ready = 1, state = IDLE.
  - sum, root, idx and the operand registers = 0.
- Latency: input handshake at edge k gives out_valid high after edge k+W+2 (k+10 for W=8).
- Output handshake at edge m gives out_valid low and in_ready high after edge m. The next input can be accepted at edge m+1.
- Throughput with out_ready held high: one result every W+4 cycles (12 for W=8).
- Back-pressure: with out_ready low, the block stays in DONE indefinitely with mag unchanged.

## Configuration
- VEC_MAG_ROUND_EN defined: mag is round-to-nearest.
  - If sum − root² > root, then mag = root + 1; otherwise mag = root.
  - This costs one compare in DONE-entry logic and adds no latency.
- VEC_MAG_ROUND_EN undefined: mag = floor(sqrt(sum)).

## Structure
- Package vec_mag_pkg holds the shared definitions:
  - the state enum (IDLE, SQ, ITER, DONE);
  - width helper functions for SUM_W and OUT_W;
  - the idx width constant $clog2(W+1).
- Sub-module vec_mag_isqrt holds the iterative root core (sum, root, idx, start and done).
- The top level holds the handshake FSM, squaring and output registers.

## Test plan
- W=8, (x,y)=(3,4), out_ready=1 → out_valid after edge k+10, mag=5; next accept at edge k+12.
- (255,255) → mag=360 without the macro, 361 with VEC_MAG_ROUND_EN. (1,1) → mag=1 in both builds. (0,0) → mag=0.
- (6,8) with out_ready low for 5 cycles after out_valid → mag=10 stable, in_ready=0 throughout. Raising out_ready completes the handshake, then in_ready=1.
- Assert rst_n low during ITER for (200,100) → out_valid=0 and mag=0 immediately (asynchronous). After release, in_ready=1; a fresh (5,12) gives mag=13.
- ena low for 3 cycles mid-ITER with (9,40) → latency extends by 3, mag=41.
- W=16 random sweep of 1000 pairs against a reference model (floor and rounded builds) → exact match, with latency 18 cycles.
